fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
// - Write-domain controller for the async FIFO. Generates the write address and strobe for the dual-port RAM.
// - Maintains binary and Gray write pointers and derives full, almost_full and fill level.
// - Input: the read-pointer Gray code after the 2-stage synchronizer. Output: the Gray write pointer, which feeds the read-domain synchronizer.
// - Sequences a drain handshake: writes are blocked until the reader has caught up.
// PARAMETERS
// - ADDR_W        4    RAM address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits; ADDR_W >= 2
// - AFULL_THRESH  12   almost_full asserts when wr_level >= AFULL_THRESH
// PORTS
// - clk             in   1         write-domain clock
// - rst_n           in   1         asynchronous active-low reset
// - wr_req          in   1         producer requests a write this cycle
// - drain_req       in   1         request drain: block writes until FIFO empty
// - rptr_gray_sync  in   ADDR_W+1  read pointer (Gray), already synchronized into clk domain
// - mem_we          out  1         RAM write strobe (combinational)
// - mem_waddr       out  ADDR_W    RAM write address = wbin[ADDR_W-1:0]
// - wptr_gray       out  ADDR_W+1  registered Gray write pointer, to read-side synchronizer
// - full            out  1         registered full flag
// - almost_full     out  1         registered, wr_level >= AFULL_THRESH
// - wr_level        out  ADDR_W+1  registered pessimistic fill level, 0..2**ADDR_W
// - drain_done      out  1         one-cycle pulse, drain complete
// - overflow        out  1         sticky: wr_req seen while full in RUN
// BEHAVIOUR
// - Reset (async, rst_n=0): wbin=0, wptr_gray=0, full=0, almost_full=0, wr_level=0, drain_done=0, overflow=0, state=RUN.
// - Reset mid-operation: everything clears immediately and the pointer restarts at 0. The read domain must be reset together with this block.
// - mem_we = wr_req & ~full & (state==RUN).
// - On each clk edge with mem_we=1: wbin <= wbin+1, with natural wrap at 2**(ADDR_W+1).
//   - wptr_gray <= bin2gray(wbin+1), updating the cycle after the write.
// - Full flag:
//   - full <= (gray_next == {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]}), where gray_next is the Gray pointer after this cycle's write.
//   - full asserts the cycle after the 2**ADDR_W-th unread write.
//   - It deasserts 1 cycle after the synchronized rptr advances.
// - wr_level <= bin_next - gray2bin(rptr_gray_sync), modulo 2**(ADDR_W+1).
//   - It is pessimistic: it never under-reports occupancy.
// - Simultaneous write and read-pointer change in one cycle: both are applied. The level uses post-write wbin and the current synchronized rptr.
// - overflow sets when wr_req & full & state==RUN. It is cleared only by reset. The rejected write changes nothing.
// - FSM:
//   - RUN: drain_req=1 -> DRAIN (the same-cycle wr_req is still accepted if not full).
//   - DRAIN: mem_we=0; wr_req is ignored and does not set overflow. Go to DONE when rptr_gray_sync == wptr_gray.
//   - DONE: drain_done=1 for exactly this cycle -> RUN. If drain_req is still high, DRAIN is re-entered on the next cycle.
// - drain_req is sampled only in RUN.
// - Encoding is 2-bit, with default -> RUN.
// CONFIGURATION
// - Macro FIFO_WR_LEVEL_EN.
// - Defined: the wr_level/almost_full logic is built as above.
// - Undefined:
//   - the gray2bin converter and subtracter are not built;
//   - wr_level ties to 0 and almost_full ties to 0;
//   - full, overflow and drain are unaffected.
// STRUCTURE
// - Package fifo_pkg holds:
//   - typedef enum logic [1:0] {RUN, DRAIN, DONE} wr_state_e;
//   - functions bin2gray and gray2bin, parameterized by width;
//   - the localparam DEPTH derivation helper.
// - One sub-module: fifo_gray_ctr, a binary+Gray pointer register with inc enable.
//   - It exposes bin, gray, bin_next and gray_next.
//   - The same module is reused by the read-side controller.
// TESTING (ADDR_W=4, AFULL_THRESH=12, rptr_gray_sync driven directly)
// - Reset: assert rst_n=0 mid-write burst -> all outputs 0 immediately, mem_waddr=0 after release.
// - Fill: rptr=0, wr_req=1 for 17 cycles
//   - -> mem_we for 16 cycles, addresses 0..15;
//   - full=1 after the 16th;
//   - wptr_gray=5'b11000 (bin 16);
//   - the 17th request sets overflow=1.
// - Level: 12 writes with rptr=0 -> almost_full=1 and wr_level=12 the cycle after the 12th write. Then set rptr_gray_sync=bin2gray(4) -> wr_level=8, almost_full=0 next cycle.
// - Wrap: write 20, read 20 (rptr=bin2gray(20)), write 16 more -> full with mem_waddr wrapping 15->0; wptr bin 36 mod 32 = 4, Gray 5'b00110.
// - Drain: 5 writes, drain_req pulse, wr_req held high -> no mem_we, no overflow. Set rptr_gray_sync=wptr_gray -> drain_done pulse 1 cycle later, then RUN and writes resume.
// - Macro off: repeat the Level scenario -> wr_level=0 and almost_full=0 throughout; full and overflow identical to macro on.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and pointer-code helpers for the async FIFO write/read controllers.
package fifo_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

    // Converters work on a wide word; callers zero-extend a narrower pointer and
    // take back the low bits, which keeps one function usable for any width.
    localparam int CVT_W = 32;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [CVT_W-1:0] bin2gray(input logic [CVT_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CVT_W-1:0] gray2bin(input logic [CVT_W-1:0] g);
        logic [CVT_W-1:0] b;
        b[CVT_W-1] = g[CVT_W-1];
        for (int i = CVT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_ctr.sv
// Binary + Gray pointer register with increment enable; shared by both FIFO sides.
module fifo_gray_ctr
    import fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] bin_o,
    output logic [W-1:0] gray_o,
    output logic [W-1:0] bin_next_o,
    output logic [W-1:0] gray_next_o
);

    logic [W-1:0]       bin_q, gray_q;
    logic [W-1:0]       bin_d, gray_d;
    logic [CVT_W-1:0]   gray_wide;
    logic [CVT_W-W-1:0] unused_gray_hi;

    assign bin_d          = bin_q + {{(W-1){1'b0}}, inc_i};
    assign gray_wide      = bin2gray({{(CVT_W-W){1'b0}}, bin_d});
    assign gray_d         = gray_wide[W-1:0];
    assign unused_gray_hi = gray_wide[CVT_W-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_o       = bin_q;
    assign gray_o      = gray_q;
    assign bin_next_o  = bin_d;
    assign gray_next_o = gray_d;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: pointers, full/level flags, drain handshake.
// Optional macro FIFO_WR_LEVEL_EN builds wr_level/almost_full; otherwise both tie to 0.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic              drain_req,
    input  logic [ADDR_W:0]   rptr_gray_sync,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              drain_done,
    output logic              overflow
);

    localparam int PTR_W = ADDR_W + 1;

    wr_state_e        state_q;
    logic             full_q, overflow_q, drain_done_q;
    logic             in_run;
    logic [PTR_W-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PTR_W-1:0] full_cmp;

    assign in_run = (state_q == RUN);
    assign mem_we = wr_req & ~full_q & in_run;

    fifo_gray_ctr #(.W(PTR_W)) u_wptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (mem_we),
        .bin_o       (wbin),
        .gray_o      (wgray),
        .bin_next_o  (wbin_next),
        .gray_next_o (wgray_next)
    );

    // Full when the post-write pointer is exactly one lap ahead of the reader:
    // in Gray code that means the top two bits inverted, the rest equal.
    assign full_cmp = {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            full_q       <= (wgray_next == full_cmp);
            drain_done_q <= 1'b0;
            if (wr_req && full_q && in_run) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (drain_req) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (rptr_gray_sync == wgray) begin
                        state_q      <= DONE;
                        drain_done_q <= 1'b1;
                    end
                end
                DONE:    state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    logic [CVT_W-1:0]       rbin_wide;
    logic [CVT_W-PTR_W-1:0] unused_rbin_hi;
    logic [PTR_W-1:0]       level_d, level_q;
    logic                   afull_d, afull_q;
    logic                   unused_wbin_msb;

    // Uses the post-write pointer against a stale read pointer, so the level
    // can only over-report occupancy.
    assign rbin_wide       = gray2bin({{(CVT_W-PTR_W){1'b0}}, rptr_gray_sync});
    assign unused_rbin_hi  = rbin_wide[CVT_W-1:PTR_W];
    assign level_d         = wbin_next - rbin_wide[PTR_W-1:0];
    assign afull_d         = ({{(CVT_W-PTR_W){1'b0}}, level_d} >= CVT_W'(AFULL_THRESH));
    assign unused_wbin_msb = wbin[ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= afull_d;
        end
    end

    assign wr_level    = level_q;
    assign almost_full = afull_q;
`else
    logic unused_level_bits;

    assign unused_level_bits = ^{wbin[ADDR_W], wbin_next, (AFULL_THRESH != 0)};
    assign wr_level          = '0;
    assign almost_full       = 1'b0;
`endif

    assign mem_waddr  = wbin[ADDR_W-1:0];
    assign wptr_gray  = wgray;
    assign full       = full_q;
    assign overflow   = overflow_q;
    assign drain_done = drain_done_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (ADDR_W=4, AFULL_THRESH=12); honours FIFO_WR_LEVEL_EN.
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic       drain_req = 1'b0;
    logic [4:0] rptr_gray_sync = '0;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [4:0] wptr_gray;
    logic       full, almost_full;
    logic [4:0] wr_level;
    logic       drain_done, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_ctrl #(.ADDR_W(4), .AFULL_THRESH(12)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req         (wr_req),
        .drain_req      (drain_req),
        .rptr_gray_sync (rptr_gray_sync),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .wr_level       (wr_level),
        .drain_done     (drain_done),
        .overflow       (overflow)
    );

    function automatic logic [4:0] g(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; wr_req = 1'b0; drain_req = 1'b0; rptr_gray_sync = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_req = 1'b1;
        end
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (wptr_gray !== 5'd0) begin n_fail++; $display("FAIL rst_wptr: got %0h expected 0", wptr_gray); end
        n_checks++; if ({full, almost_full, drain_done, overflow} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {full, almost_full, drain_done, overflow}); end
        n_checks++; if (wr_level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", wr_level); end
        repeat (18) begin
            @(negedge clk);
            wr_req = 1'b1;
        end
        #2;
        n_checks++; if ({full, overflow} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_flags: got %b expected 11", {full, overflow}); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (wptr_gray !== 5'd0) begin n_fail++; $display("FAIL rst_async_wptr: got %0h expected 0", wptr_gray); end
        n_checks++; if (mem_waddr !== 4'd0) begin n_fail++; $display("FAIL rst_async_waddr: got %0d expected 0", mem_waddr); end
        n_checks++; if ({full, almost_full, drain_done, overflow} !== 4'b0) begin n_fail++; $display("FAIL rst_async_flags: got %b expected 0000", {full, almost_full, drain_done, overflow}); end
        n_checks++; if (wr_level !== 5'd0) begin n_fail++; $display("FAIL rst_async_level: got %0d expected 0", wr_level); end
        wr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_waddr !== 4'd0) begin n_fail++; $display("FAIL rst_release_waddr: got %0d expected 0", mem_waddr); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wr_req = 1'b1;
            #1;
            n_checks++; if (mem_we !== (i < 16)) begin n_fail++; $display("FAIL fill_we[%0d]: got %b expected %b", i, mem_we, (i < 16)); end
            if (i < 16) begin
                n_checks++; if (mem_waddr !== i[3:0]) begin n_fail++; $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, mem_waddr, i); end
            end
            if (i == 16) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early: got %b expected 0", overflow); end
            end
        end
        @(negedge clk);
        wr_req = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b expected 1", overflow); end
        n_checks++; if (wptr_gray !== 5'b11000) begin n_fail++; $display("FAIL fill_wptr: got %b expected 11000", wptr_gray); end
        n_checks++; if (wr_level !== (LVL_EN ? 5'd16 : 5'd0)) begin n_fail++; $display("FAIL fill_level: got %0d expected %0d", wr_level, (LVL_EN ? 16 : 0)); end
        n_checks++; if (almost_full !== LVL_EN) begin n_fail++; $display("FAIL fill_afull: got %b expected %b", almost_full, LVL_EN); end
    endtask

    task automatic test_level();
        do_reset();
        push(11);
        n_checks++; if (wr_level !== (LVL_EN ? 5'd11 : 5'd0)) begin n_fail++; $display("FAIL lvl_11: got %0d expected %0d", wr_level, (LVL_EN ? 11 : 0)); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL lvl_afull_11: got %b expected 0", almost_full); end
        push(1);
        n_checks++; if (wr_level !== (LVL_EN ? 5'd12 : 5'd0)) begin n_fail++; $display("FAIL lvl_12: got %0d expected %0d", wr_level, (LVL_EN ? 12 : 0)); end
        n_checks++; if (almost_full !== LVL_EN) begin n_fail++; $display("FAIL lvl_afull_12: got %b expected %b", almost_full, LVL_EN); end
        n_checks++; if ({full, overflow} !== 2'b00) begin n_fail++; $display("FAIL lvl_full_ovf: got %b expected 00", {full, overflow}); end
        rptr_gray_sync = g(4);
        #1;
        n_checks++; if (wr_level !== (LVL_EN ? 5'd12 : 5'd0)) begin n_fail++; $display("FAIL lvl_hold: got %0d expected %0d", wr_level, (LVL_EN ? 12 : 0)); end
        @(negedge clk);
        n_checks++; if (wr_level !== (LVL_EN ? 5'd8 : 5'd0)) begin n_fail++; $display("FAIL lvl_8: got %0d expected %0d", wr_level, (LVL_EN ? 8 : 0)); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL lvl_afull_8: got %b expected 0", almost_full); end
    endtask

    task automatic test_wrap();
        do_reset();
        push(10);
        rptr_gray_sync = g(10);
        push(10);
        rptr_gray_sync = g(20);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_req = 1'b1;
            #1;
            n_checks++; if ({mem_we, mem_waddr} !== {1'b1, 4'((20 + i) % 16)}) begin n_fail++; $display("FAIL wrap_we_addr[%0d]: got %b/%0d expected 1/%0d", i, mem_we, mem_waddr, (20 + i) % 16); end
            if (i == 15) begin
                n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full_early: got %b expected 0", full); end
            end
        end
        @(negedge clk);
        wr_req = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %b expected 1", full); end
        n_checks++; if (wptr_gray !== 5'b00110) begin n_fail++; $display("FAIL wrap_wptr: got %b expected 00110", wptr_gray); end
        n_checks++; if (wr_level !== (LVL_EN ? 5'd16 : 5'd0)) begin n_fail++; $display("FAIL wrap_level: got %0d expected %0d", wr_level, (LVL_EN ? 16 : 0)); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_drain();
        do_reset();
        repeat (4) begin
            @(negedge clk);
            wr_req = 1'b1;
        end
        @(negedge clk);
        drain_req = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL drain_same_cycle_we: got %b expected 1", mem_we); end
        @(negedge clk);
        drain_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if ({mem_we, drain_done, overflow} !== 3'b000) begin n_fail++; $display("FAIL drain_block[%0d]: got %b expected 000", i, {mem_we, drain_done, overflow}); end
            @(negedge clk);
        end
        n_checks++; if (wptr_gray !== g(5)) begin n_fail++; $display("FAIL drain_wptr: got %b expected %b", wptr_gray, g(5)); end
        rptr_gray_sync = g(5);
        #1;
        n_checks++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_done_early: got %b expected 0", drain_done); end
        @(negedge clk);
        n_checks++; if ({drain_done, mem_we} !== 2'b10) begin n_fail++; $display("FAIL drain_done_pulse: got %b expected 10", {drain_done, mem_we}); end
        @(negedge clk);
        n_checks++; if ({drain_done, mem_we} !== 2'b01) begin n_fail++; $display("FAIL drain_resume: got %b expected 01", {drain_done, mem_we}); end
        @(negedge clk);
        wr_req = 1'b0;
        n_checks++; if (wptr_gray !== g(6)) begin n_fail++; $display("FAIL drain_wptr_after: got %b expected %b", wptr_gray, g(6)); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL drain_ovf: got %b expected 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_level();
        test_wrap();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
